mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 44 ++++
 rtl/mc_decode.sv | 56 +++++
 rtl/mc_ctrl.sv | 150 +++++++++++++++
 tb/tb_mc_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_JAL, C_JALR, C_ILL
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DRAM = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;

  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: class, immediate format, ALU op, illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  cls,
  output logic [2:0]  sext_op,
  output logic [3:0]  alu_op,
  output logic        illegal
);

  logic [2:0] funct3;
  logic       unused_bits;

  assign funct3      = inst[14:12];
  assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    cls     = C_ILL;
    sext_op = SEXT_I;
    alu_op  = ALU_ADD;
    case (inst[6:0])
      OP_R: begin
        cls    = C_R;
        alu_op = {inst[30], funct3};
      end
      OP_I: begin
        cls    = C_I;
        alu_op = {inst[30] & (funct3 == 3'b101), funct3};
      end
      OP_LOAD:  cls = C_LOAD;
      OP_STORE: begin
        cls     = C_STORE;
        sext_op = SEXT_S;
      end
      OP_BRANCH: begin
        cls     = C_BRANCH;
        sext_op = SEXT_B;
        alu_op  = ALU_SUB;
      end
      OP_LUI: begin
        cls     = C_LUI;
        sext_op = SEXT_U;
      end
      OP_JAL: begin
        cls     = C_JAL;
        sext_op = SEXT_J;
      end
      OP_JALR: cls = C_JALR;
      default: cls = C_ILL;
    endcase
  end

  assign illegal = (cls == C_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM with DRAM wait timeout and sticky trap.
// Optional perf counters (instret, stall_cnt) when MC_CTRL_PERF_EN is defined.
//   state  | meaning
//   FETCH  | load IR
//   DECODE | classify opcode, illegal -> TRAP
//   EXEC   | ALU op; branches retire here
//   MEM    | DRAM access, wait for dram_ready; stores retire here
//   WB     | register write-back and PC update
//   TRAP   | fault, held until reset
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        br_true,
  input  logic        dram_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_op,
  output logic        rf_we,
  output logic [1:0]  wd_sel,
  output logic [2:0]  sext_op,
  output logic [3:0]  alu_op,
  output logic        dram_req,
  output logic        dram_we,
  output logic [2:0]  state,
  output logic        trap
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt;
  logic [3:0] cls;
  logic       illegal;
  logic       is_mem;

  mc_decode u_decode (
    .inst    (inst),
    .cls     (cls),
    .sext_op (sext_op),
    .alu_op  (alu_op),
    .illegal (illegal)
  );

  assign is_mem = (cls == C_LOAD) || (cls == C_STORE);
  assign state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // The timeout fires on the wait that would bring the count to WAIT_MAX;
  // a ready strobe in that same cycle still wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (is_mem)                 state_d = S_MEM;
        else if (cls == C_BRANCH)   state_d = S_FETCH;
        else                        state_d = S_WB;
      end
      S_MEM: begin
        if (dram_ready)                state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
        else if (wait_cnt == WAIT_LAST) state_d = S_TRAP;
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    dram_req = 1'b0;
    dram_we  = 1'b0;
    npc_op   = NPC_PC4;
    wd_sel   = WD_ALU;
    case (cls)
      C_BRANCH: npc_op = br_true ? NPC_BR : NPC_PC4;
      C_JAL:    npc_op = NPC_JAL;
      C_JALR:   npc_op = NPC_JALR;
      default:  npc_op = NPC_PC4;
    endcase
    case (cls)
      C_LOAD:         wd_sel = WD_DRAM;
      C_JAL, C_JALR:  wd_sel = WD_PC4;
      default:        wd_sel = WD_ALU;
    endcase
    // Enables are gated by rst_n so nothing fires while reset is held.
    if (rst_n) begin
      case (state_q)
        S_FETCH: ir_we = 1'b1;
        S_EXEC:  pc_we = (cls == C_BRANCH);
        S_MEM: begin
          dram_req = 1'b1;
          dram_we  = (cls == C_STORE);
          pc_we    = (cls == C_STORE) && dram_ready;
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
      trap     <= 1'b0;
    end else begin
      if (state_q == S_EXEC)
        wait_cnt <= 4'd0;
      else if (state_q == S_MEM && !dram_ready)
        wait_cnt <= wait_cnt + 4'd1;
      if (state_d == S_TRAP)
        trap <= 1'b1;
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret   <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (pc_we)
        instret <= instret + 32'd1;
      if (state_q == S_MEM && !dram_ready)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expectations queued per instruction, checked each cycle.
module tb_mc_ctrl;

  localparam int WM = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        br_true;
  logic        dram_ready;
  logic        ir_we, pc_we, rf_we, dram_req, dram_we, trap;
  logic [1:0]  npc_op, wd_sel;
  logic [2:0]  sext_op, state;
  logic [3:0]  alu_op;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instret, stall_cnt;
`endif

  mc_ctrl #(.WAIT_MAX(WM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .br_true    (br_true),
    .dram_ready (dram_ready),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .npc_op     (npc_op),
    .rf_we      (rf_we),
    .wd_sel     (wd_sel),
    .sext_op    (sext_op),
    .alu_op     (alu_op),
    .dram_req   (dram_req),
    .dram_we    (dram_we),
    .state      (state),
    .trap       (trap)
`ifdef MC_CTRL_PERF_EN
    ,
    .instret    (instret),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        br;
    logic        rdy;
    logic        rnd;
    logic [19:0] exp;
    logic [19:0] msk;
    string       tag;
  } rec_t;

  rec_t q[$];

  int checks = 0;
  int errors = 0;

  string       cur_tag;
  logic [31:0] cur_inst;
  logic        cur_br;
  logic [2:0]  cur_sx;
  logic        cur_sx_dc;
  logic [3:0]  cur_al;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;

  task automatic begin_ins(input string t, input logic [31:0] i, input logic br,
                           input logic [2:0] sx, input logic sx_dc, input logic [3:0] al);
    cur_tag = t; cur_inst = i; cur_br = br; cur_sx = sx; cur_sx_dc = sx_dc; cur_al = al;
  endtask

  task automatic cyc(input logic [2:0] st, input logic ir, input logic pc, input logic [1:0] npc,
                     input logic rf, input logic [1:0] wd, input logic rq, input logic dw,
                     input logic tr, input logic rdy, input logic rnd);
    rec_t r;
    r.inst = cur_inst; r.br = cur_br; r.rdy = rdy; r.rnd = rnd; r.tag = cur_tag;
    r.exp  = {st, ir, pc, npc, rf, wd, rq, dw, tr, cur_sx, cur_al};
    r.msk  = 20'hFFFFF;
    if (!pc) r.msk[14:13] = 2'b00;
    if (!rf) r.msk[11:10] = 2'b00;
    if (cur_sx_dc) r.msk[6:4] = 3'b000;
    q.push_back(r);
  endtask

  task automatic head();
    cyc(F, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1);
    cyc(D, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1);
  endtask

  task automatic ins_alu(input string t, input logic [31:0] i, input logic [2:0] sx,
                         input logic sx_dc, input logic [3:0] al, input logic [1:0] npc,
                         input logic [1:0] wd);
    begin_ins(t, i, $urandom_range(0, 1), sx, sx_dc, al);
    head();
    cyc(E, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1);
    cyc(W, 0, 1, npc, 1, wd, 0, 0, 0, 0, 1);
  endtask

  task automatic ins_br(input string t, input logic [31:0] i, input logic br);
    begin_ins(t, i, br, 3'd2, 0, 4'b1000);
    head();
    cyc(E, 0, 1, br ? 2'b01 : 2'b00, 0, 2'b00, 0, 0, 0, 0, 1);
  endtask

  task automatic mem_prefix(input string t, input logic [31:0] i, input logic st, input int n);
    begin_ins(t, i, 1'b0, st ? 3'd1 : 3'd0, 0, 4'b0000);
    head();
    cyc(E, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1);
    for (int k = 0; k < n; k++) cyc(M, 0, 0, 2'b00, 0, 2'b00, 1, st, 0, 0, 0);
  endtask

  task automatic ins_ld(input string t, input logic [31:0] i, input int w);
    mem_prefix(t, i, 0, w);
    cyc(M, 0, 0, 2'b00, 0, 2'b00, 1, 0, 0, 1, 0);
    cyc(W, 0, 1, 2'b00, 1, 2'b01, 0, 0, 0, 0, 1);
  endtask

  task automatic ins_st(input string t, input logic [31:0] i, input int w);
    mem_prefix(t, i, 1, w);
    cyc(M, 0, 1, 2'b00, 0, 2'b00, 1, 1, 0, 1, 0);
  endtask

  task automatic trap_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(T, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1, 0, 1);
  endtask

  task automatic run();
    rec_t r;
    logic [19:0] obs;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      inst       = r.inst;
      br_true    = r.br;
      dram_ready = r.rnd ? 1'($urandom_range(0, 1)) : r.rdy;
      #1;
      obs = {state, ir_we, pc_we, npc_op, rf_we, wd_sel, dram_req, dram_we, trap, sext_op, alu_op};
      checks++;
      assert ((obs & r.msk) === (r.exp & r.msk))
      else begin
        errors++;
        $error("FAIL %s st=%0d observed=%h expected=%h mask=%h", r.tag, r.exp[19:17], obs, r.exp, r.msk);
      end
    end
  endtask

  task automatic chk_reset(input string t);
    checks++;
    assert ({state, ir_we, pc_we, rf_we, dram_req, dram_we, trap} === 9'b0)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=000000000", t,
             {state, ir_we, pc_we, rf_we, dram_req, dram_we, trap});
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    assert ({instret, stall_cnt} === 64'd0)
    else begin
      errors++;
      $error("FAIL %s_perf observed=%0d/%0d expected=0/0", t, instret, stall_cnt);
    end
`endif
  endtask

  task automatic do_reset(input string t);
    @(negedge clk);
    rst_n = 1'b0;
    dram_ready = 1'b1;
    #1 chk_reset(t);
    @(posedge clk);
    #1 chk_reset({t, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst = 32'h0; br_true = 1'b0; dram_ready = 1'b0;
    #1 chk_reset("reset_init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    ins_alu("add",  32'h002081B3, 3'd0, 1, 4'b0000, 2'b00, 2'b00);
    ins_alu("sub",  32'h402081B3, 3'd0, 1, 4'b1000, 2'b00, 2'b00);
    ins_alu("srai", 32'h4030D193, 3'd0, 0, 4'b1101, 2'b00, 2'b00);
    ins_alu("lui",  32'h123451B7, 3'd3, 0, 4'b0000, 2'b00, 2'b00);
    ins_alu("jal",  32'h008000EF, 3'd4, 0, 4'b0000, 2'b10, 2'b10);
    ins_alu("jalr", 32'h000080E7, 3'd0, 0, 4'b0000, 2'b11, 2'b10);
    ins_ld("lw_w2", 32'h0000A183, 2);
    ins_br("beq_t", 32'h00208463, 1'b1);
    ins_br("beq_nt", 32'h00208463, 1'b0);
    ins_st("sw_w0", 32'h0020A023, 0);
    ins_st("sw_edge", 32'h0020A023, WM - 1);
    ins_ld("lw_w0", 32'h0000A183, 0);
    run();

    mem_prefix("sw_timeout", 32'h0020A023, 1, WM);
    trap_cycles(4);
    run();
    do_reset("reset_trap");

    ins_alu("add_post", 32'h002081B3, 3'd0, 1, 4'b0000, 2'b00, 2'b00);
    begin_ins("illegal", 32'h0000007F, 1'b0, 3'd0, 1, 4'b0000);
    head();
    trap_cycles(3);
    run();
    do_reset("reset_illegal");

    mem_prefix("lw_abort", 32'h0000A183, 0, 2);
    run();
    do_reset("reset_mem");

    ins_alu("add_perf", 32'h002081B3, 3'd0, 1, 4'b0000, 2'b00, 2'b00);
    ins_ld("lw_perf", 32'h0000A183, 2);
    ins_br("beq_perf", 32'h00208463, 1'b1);
    run();
`ifdef MC_CTRL_PERF_EN
    checks++;
    assert (instret === 32'd3)
    else begin
      errors++;
      $error("FAIL instret observed=%0d expected=3", instret);
    end
    checks++;
    assert (stall_cnt === 32'd2)
    else begin
      errors++;
      $error("FAIL stall_cnt observed=%0d expected=2", stall_cnt);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
